booth_mul_arbiter: RTL and testbench



---
 rtl/booth_mul_arbiter.sv | 153 +++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two requesters share one sequential radix-2 Booth multiplier
// under round-robin arbitration. Each RUN cycle performs one Booth step.
// Optional build macro BOOTH_EARLY_TERM_EN: a run ends as soon as the
// remaining multiplier bits are all copies of the current bit.
module booth_mul_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 resp_valid,
   output logic                 resp_id,
   output logic [2*WIDTH-1:0]   resp_product,
   output logic [CNTW-1:0]      resp_add_ops,
   output logic [CNTW-1:0]      resp_sub_ops,
   output logic                 busy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_next;
   logic              last_grant, cur_id;
   logic              grant0, grant1;
   logic [PW-1:0]     a_ext, acc, acc_next;
   logic [WIDTH-1:0]  b_reg;
   logic [CNTW-1:0]   step, add_cnt, sub_cnt, add_next, sub_next;
   logic              prev_bit, cur_bit, last_step;

   // Round-robin grant: a lone requester wins; on contention the one not granted last wins
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign cur_bit = b_reg[step[IW-1:0]];

`ifdef BOOTH_EARLY_TERM_EN
   logic signed [WIDTH-1:0] b_rem;
   // Remaining multiplier bits all equal to B[i] means every later step is a no-op
   assign b_rem     = $signed(b_reg) >>> step[IW-1:0];
   assign last_step = (step == CNTW'(WIDTH - 1)) || (b_rem == '0) || (b_rem == '1);
`else
   assign last_step = (step == CNTW'(WIDTH - 1));
`endif

   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state, handshake and Booth step arithmetic
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      acc_next   = acc;
      add_next   = add_cnt;
      sub_next   = sub_cnt;
      case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 | grant1) state_next = RUN;
         end
         RUN: begin
            case ({cur_bit, prev_bit})
               2'b10: begin
                  acc_next = acc - (a_ext << step);
                  sub_next = sub_cnt + CNTW'(1);
               end
               2'b01: begin
                  acc_next = acc + (a_ext << step);
                  add_next = add_cnt + CNTW'(1);
               end
               default: ;
            endcase
            if (last_step) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, datapath registers and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant   <= 1'b1;
         cur_id       <= 1'b0;
         a_ext        <= '0;
         b_reg        <= '0;
         acc          <= '0;
         add_cnt      <= '0;
         sub_cnt      <= '0;
         step         <= '0;
         prev_bit     <= 1'b0;
         resp_id      <= 1'b0;
         resp_product <= '0;
         resp_add_ops <= '0;
         resp_sub_ops <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready | req1_ready) begin
                  if (req1_ready) begin
                     a_ext <= {{WIDTH{req1_a[WIDTH-1]}}, req1_a};
                     b_reg <= req1_b;
                  end else begin
                     a_ext <= {{WIDTH{req0_a[WIDTH-1]}}, req0_a};
                     b_reg <= req0_b;
                  end
                  cur_id     <= req1_ready;
                  last_grant <= req1_ready;
                  acc        <= '0;
                  add_cnt    <= '0;
                  sub_cnt    <= '0;
                  step       <= '0;
                  prev_bit   <= 1'b0;
               end
            end
            RUN: begin
               acc      <= acc_next;
               add_cnt  <= add_next;
               sub_cnt  <= sub_next;
               prev_bit <= cur_bit;
               step     <= step + CNTW'(1);
               if (last_step) begin
                  resp_product <= acc_next;
                  resp_add_ops <= add_next;
                  resp_sub_ops <= sub_next;
                  resp_id      <= cur_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter (WIDTH=32): products, op counts,
// latency, round-robin order and reset during a run.
module tb_booth_mul_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          resp_valid, resp_id, busy;
   logic [2*W-1:0] resp_product;
   logic [5:0]    resp_add_ops, resp_sub_ops;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
      .resp_add_ops(resp_add_ops), .resp_sub_ops(resp_sub_ops), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation from a single requester, checked end to end
   task automatic run_op(input string tag, input logic rq, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] ep,
                         input int ea, input int es, input int elat);
      bit got;
      int n;
      @(negedge clk);
      if (rq) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         #1;
         if ((rq ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      chk({tag, "_grant"}, 64'(got), 64'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (resp_valid === 1'b1) break;
      end
      chk({tag, "_latency"}, 64'(n), 64'(elat));
      chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_id"}, 64'(resp_id), 64'(rq));
      chk({tag, "_product"}, resp_product, ep);
      chk({tag, "_add_ops"}, 64'(resp_add_ops), 64'(ea));
      chk({tag, "_sub_ops"}, 64'(resp_sub_ops), 64'(es));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, resp_product, ep);
   endtask

   initial begin
      int lat_35, lat_m76, lat_9m1, grants;
      logic exp_id;
`ifdef BOOTH_EARLY_TERM_EN
      lat_35 = 4; lat_m76 = 4; lat_9m1 = 1;
`else
      lat_35 = W; lat_m76 = W; lat_9m1 = W;
`endif
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_product", resp_product, 64'd0);
      chk("rst_add", 64'(resp_add_ops), 64'd0);
      chk("rst_sub", 64'(resp_sub_ops), 64'd0);
      chk("rst_id", 64'(resp_id), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("r0_3x5", 1'b0, 32'd3, 32'd5, 64'd15, 2, 2, lat_35);
      run_op("r1_m7x6", 1'b1, -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1, 1, lat_m76);
      run_op("r0_9xm1", 1'b0, 32'd9, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7, 0, 1, lat_9m1);
      run_op("r0_max", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0, 1, W);

      // Both requesters valid from reset: grants must alternate 0,1,0,1
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd5;
      grants = 0;
      exp_id = 1'b0;
      for (int c = 0; c < 4 * (W + 2) + 20 && grants < 4; c++) begin
         #1;
         chk("rr_both_ready", 64'(req0_ready & req1_ready), 64'd0);
         if (req0_ready | req1_ready) begin
            chk("rr_order", 64'(req1_ready), 64'(exp_id));
            chk("rr_ready_idle", 64'(busy), 64'd0);
            exp_id = ~exp_id;
            grants++;
         end
         if (resp_valid === 1'b1)
            chk("rr_product", resp_product, resp_id ? 64'd20 : 64'd6);
         @(negedge clk);
      end
      chk("rr_grants", 64'(grants), 64'd4);

      // Reset at step 10 drops the op and restores the pointer
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'h5555_5555;
      req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'h5555_5555;
      #1;
      chk("mid_first_grant", 64'({req1_ready, req0_ready}), 64'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_running", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_no_valid", 64'(resp_valid), 64'd0);
      reset = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("mid_regrant", 64'({req1_ready, req0_ready}), 64'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
